decrypter_core: RTL and testbench
=================================

DECRYPTER_CORE -- requirements
Module: decrypter_core

Interface
REQ-001 Parameter ROUNDS, default 8, number of decryption rounds; legal range 1..12.
REQ-002 Parameter ROT, default 7, per-round rotate distance in bits; legal range 1..59.
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  ciphertext and key present.
REQ-006 in_ready  output  1  block can accept a ciphertext this cycle.
REQ-007 data_to_be_decrypt  input  76  ciphertext: [75:60] tag T, [59:0] body B.
REQ-008 key  input  60  key word, sourced from the password generator output.
REQ-009 out_valid  output  1  plaintext result available.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 output_decrypted  output  60  recovered plaintext P.
REQ-012 tag_ok  output  1  1 means the recomputed tag equals received T; meaningful only while out_valid is high.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, CHECK and DONE.
REQ-015 in_ready SHALL be high only in IDLE.
REQ-016 Accept SHALL be defined as in_ready & in_valid. On accept, the block SHALL latch S<=B, T, and the key, set round counter r<=ROUNDS-1, and go to RUN.
REQ-017 Round key: K_r = rotl(key, (5*r) mod 60) XOR {56'b0, r[3:0]}.
REQ-018 Each RUN cycle SHALL perform S <= rotr(S XOR K_r, ROT) as a 60-bit rotate, then decrement r.
REQ-019 The round with r=0 SHALL be the last; that cycle SHALL move the FSM to CHECK.
REQ-020 This is the exact inverse of the encrypter round S <= rotl(S,ROT) XOR K_r, applied for r=0..ROUNDS-1.
REQ-021 In CHECK, the block SHALL compute Tc = {^S, S[59:45]^S[44:30]^S[29:15]^S[14:0]} (16 bits).
REQ-022 In CHECK, the block SHALL register output_decrypted<=S and tag_ok<=(Tc==T), then go to DONE.
REQ-023 out_valid SHALL be high exactly in DONE, first asserted ROUNDS+1 cycles after the accept edge.
REQ-024 While out_valid & !out_ready, output_decrypted and tag_ok SHALL hold stable.
REQ-025 DONE & out_ready SHALL return the FSM to IDLE; the next accept is possible one cycle later.
REQ-026 Minimum interval between accepts SHALL be ROUNDS+3 cycles.
REQ-027 A tag mismatch SHALL NOT suppress delivery: the plaintext is still output, with tag_ok=0.
REQ-028 in_valid outside IDLE SHALL be ignored; the input registers SHALL NOT change.
REQ-029 Changes on data_to_be_decrypt or key after accept SHALL NOT affect the result in flight.
REQ-030 out_ready outside DONE SHALL have no effect.
REQ-031 With ROUNDS=1, the block SHALL run exactly one RUN cycle, using r=0.

Reset
REQ-032 Rst high at a clock edge SHALL force IDLE from any state and abort any operation in flight.
REQ-033 During and after reset: output_decrypted=0, tag_ok=0, out_valid=0, busy=0, in_ready=1 (the first cycle after Rst deasserts).
REQ-034 Internal S, T, latched key and r SHALL be cleared to 0.
REQ-035 Rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-036 ROUNDS=1, ROT=7, key=0, C=0x8001_0000_0000_0000_080 -> out_valid 2 cycles after accept, output_decrypted=0x000_0000_0000_0001, tag_ok=1.
REQ-037 Same stimulus with C[75] flipped (T=0x0001) -> output_decrypted=0x...001 unchanged, tag_ok=0.
REQ-038 Default params; 1000 random P and key encrypted by the bench reference model -> every output equals P, tag_ok=1, out_valid exactly 9 cycles after each accept.
REQ-039 Hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable for 5 cycles; in_ready=0 and in_valid pulses ignored; release -> IDLE next cycle.
REQ-040 Pulse Rst at RUN round 4 -> next cycle IDLE, all outputs 0, in_ready=1; a new accept decrypts correctly with no residue.
REQ-041 Back-to-back requests with in_valid held high and out_ready=1 -> one accept every 11 cycles (ROUNDS=8), results in order.

Source files
------------

// File: rtl/decrypter_core.sv
// Iterative block decrypter: undoes ROUNDS rotate/XOR rounds on a 60-bit body,
// then recomputes a 16-bit tag and compares it with the received one.
module decrypter_core #(
  parameter int ROUNDS = 8,
  parameter int ROT    = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [75:0] data_to_be_decrypt,
  input  logic [59:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] output_decrypted,
  output logic        tag_ok,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] R_FIRST = 4'(ROUNDS - 1);
  localparam logic [5:0] ROTR_AS_ROTL = 6'(60 - ROT);

  state_t      state;
  state_t      state_nxt;
  logic [59:0] s_reg;
  logic [59:0] key_reg;
  logic [15:0] t_reg;
  logic [3:0]  r_reg;
  logic        accept;
  logic [6:0]  five_r;
  logic [5:0]  key_rot;
  logic [59:0] round_key;
  logic [59:0] round_out;
  logic [15:0] tag_calc;

  // Upper half of the doubled word shifted left is the 60-bit left rotation (n < 60).
  function automatic logic [59:0] rotl60(input logic [59:0] x, input logic [5:0] n);
    logic [119:0] dbl;
    dbl = {x, x} << n;
    return dbl[119:60];
  endfunction

  assign accept = in_ready & in_valid;

  always_comb begin
    five_r    = 7'(r_reg) * 7'd5;
    key_rot   = (five_r >= 7'd60) ? 6'(five_r - 7'd60) : 6'(five_r);
    round_key = rotl60(key_reg, key_rot) ^ {56'b0, r_reg};
    round_out = rotl60(s_reg ^ round_key, ROTR_AS_ROTL);
    tag_calc  = {^s_reg, s_reg[59:45] ^ s_reg[44:30] ^ s_reg[29:15] ^ s_reg[14:0]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (r_reg == 4'd0) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The round counter parks at 0 after the last round instead of wrapping.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s_reg            <= '0;
      key_reg          <= '0;
      t_reg            <= '0;
      r_reg            <= '0;
      output_decrypted <= '0;
      tag_ok           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s_reg   <= data_to_be_decrypt[59:0];
            t_reg   <= data_to_be_decrypt[75:60];
            key_reg <= key;
            r_reg   <= R_FIRST;
          end
        end
        RUN: begin
          s_reg <= round_out;
          if (r_reg != 4'd0) r_reg <= r_reg - 4'd1;
        end
        CHECK: begin
          output_decrypted <= s_reg;
          tag_ok           <= (tag_calc == t_reg);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decrypter_core.sv
// Directed and model-driven bench for decrypter_core: a reference encrypter
// builds ciphertexts, and a ROUNDS=1 instance covers the single-round vectors.
module tb_decrypter_core;

  localparam int TB_ROUNDS = 8;
  localparam int TB_ROT    = 7;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid1 = 1'b0;
  logic [75:0] data_to_be_decrypt = '0;
  logic [59:0] key = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, tag_ok, busy;
  logic [59:0] output_decrypted;
  logic        in_ready1, out_valid1, tag_ok1, busy1;
  logic [59:0] output_decrypted1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [59:0] p;
    logic [59:0] k;
    logic [15:0] tag_flip;
    logic        exp_tag_ok;
  } vec_t;

  always #5 Clk = ~Clk;

  decrypter_core #(.ROUNDS(TB_ROUNDS), .ROT(TB_ROT)) u_dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_to_be_decrypt(data_to_be_decrypt), .key(key),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_decrypted(output_decrypted), .tag_ok(tag_ok), .busy(busy)
  );

  decrypter_core #(.ROUNDS(1), .ROT(7)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .data_to_be_decrypt(data_to_be_decrypt), .key(key),
    .out_valid(out_valid1), .out_ready(out_ready),
    .output_decrypted(output_decrypted1), .tag_ok(tag_ok1), .busy(busy1)
  );

  function automatic logic [59:0] ref_rotl(input logic [59:0] x, input int n);
    int m;
    m = n % 60;
    if (m == 0) return x;
    return (x << m) | (x >> (60 - m));
  endfunction

  function automatic logic [15:0] ref_tag(input logic [59:0] p);
    return {^p, p[59:45] ^ p[44:30] ^ p[29:15] ^ p[14:0]};
  endfunction

  // Forward cipher: S <= rotl(S,ROT) ^ K_r for r = 0..rounds-1.
  function automatic logic [75:0] ref_encrypt(input logic [59:0] p, input logic [59:0] k,
                                              input int rounds);
    logic [59:0] s;
    logic [59:0] kr;
    s = p;
    for (int r = 0; r < rounds; r++) begin
      kr = ref_rotl(k, 5 * r) ^ {56'b0, 4'(r)};
      s  = ref_rotl(s, TB_ROT) ^ kr;
    end
    return {ref_tag(p), s};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One full transaction on the default instance; inputs are scrambled and
  // in_valid kept high while the block is busy.
  task automatic applyStimulus(input string name, input logic [75:0] ct,
                               input logic [59:0] k, input logic [59:0] exp_p,
                               input logic exp_ok);
    int wait_cyc;
    int lat;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
    in_valid           = 1'b1;
    data_to_be_decrypt = ct;
    key                = k;
    out_ready          = 1'b1;
    tick();
    data_to_be_decrypt = ~ct;
    key                = ~k;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checkOutput({name, "_latency"}, 64'(lat), 64'(TB_ROUNDS + 1));
    checkOutput({name, "_plain"}, 64'(output_decrypted), 64'(exp_p));
    checkOutput({name, "_tag_ok"}, 64'(tag_ok), 64'(exp_ok));
    tick();
    checkOutput({name, "_idle_after"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  vec_t vecs[6];

  initial begin
    logic [59:0] rp, rk, hold_p;
    logic [75:0] ct;
    int          lat, cyc, n_acc, n_out;
    int          acc_cyc[3];
    logic [59:0] b2b_p[3];
    logic [59:0] b2b_k[3];
    logic        acc_now;

    vecs[0] = '{"zero",      60'h0,               60'h0,               16'h0, 1'b1};
    vecs[1] = '{"ones_p",    60'hFFF_FFFF_FFFF_FFFF, 60'h0,            16'h0, 1'b1};
    vecs[2] = '{"ones_key",  60'h0,               60'hFFF_FFFF_FFFF_FFFF, 16'h0, 1'b1};
    vecs[3] = '{"mixed",     60'h123_4567_89AB_CDEF, 60'hFED_CBA9_8765_4321, 16'h0, 1'b1};
    vecs[4] = '{"bad_tag_lo", 60'h800_0000_0000_0001, 60'h0F0_F0F0_F0F0_F0F0, 16'h0001, 1'b0};
    vecs[5] = '{"bad_tag_hi", 60'hA5A_5A5A_5A5A_5A5A, 60'h5A5_A5A5_A5A5_A5A5, 16'h8000, 1'b0};

    repeat (3) tick();
    checkOutput("rst_during", 64'({in_ready, out_valid, busy, tag_ok}), 64'b1000);
    Rst = 1'b0;
    tick();
    checkOutput("rst_after_ctrl", 64'({in_ready, out_valid, busy, tag_ok}), 64'b1000);
    checkOutput("rst_after_data", 64'(output_decrypted), 64'h0);

    for (int i = 0; i < 6; i++) begin
      ct = ref_encrypt(vecs[i].p, vecs[i].k, TB_ROUNDS);
      ct[75:60] = ct[75:60] ^ vecs[i].tag_flip;
      applyStimulus(vecs[i].name, ct, vecs[i].k, vecs[i].p, vecs[i].exp_tag_ok);
    end

    for (int i = 0; i < 1000; i++) begin
      rp = 60'({$urandom(), $urandom()});
      rk = 60'({$urandom(), $urandom()});
      applyStimulus("random", ref_encrypt(rp, rk, TB_ROUNDS), rk, rp, 1'b1);
    end

    // Consumer stalls for 5 cycles while in_valid keeps pulsing.
    hold_p = 60'h0DE_CAF0_1234_5678;
    in_valid = 1'b1;
    data_to_be_decrypt = ref_encrypt(hold_p, 60'h333, TB_ROUNDS);
    key = 60'h333;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("hold_latency", 64'(lat), 64'(TB_ROUNDS + 1));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      data_to_be_decrypt = 76'(i);
      tick();
      checkOutput("hold_ctrl", 64'({out_valid, in_ready, busy, tag_ok}), 64'b1011);
      checkOutput("hold_plain", 64'(output_decrypted), 64'(hold_p));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("hold_release", 64'({in_ready, out_valid, busy}), 64'b100);

    // Abort mid-run with reset; outputs still hold hold_p until then.
    in_valid = 1'b1;
    data_to_be_decrypt = ref_encrypt(60'h111, 60'h222, TB_ROUNDS);
    key = 60'h222;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checkOutput("abort_busy", 64'(busy), 64'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checkOutput("abort_ctrl", 64'({in_ready, out_valid, busy, tag_ok}), 64'b1000);
    checkOutput("abort_plain", 64'(output_decrypted), 64'h0);
    applyStimulus("post_abort", ref_encrypt(60'h0BA_D00D_CAFE_F00D, 60'h777_1234_5678_9ABC,
                  TB_ROUNDS), 60'h777_1234_5678_9ABC, 60'h0BA_D00D_CAFE_F00D, 1'b1);

    // Back-to-back with in_valid held high.
    for (int i = 0; i < 3; i++) begin
      b2b_p[i] = 60'h100 * 60'(i + 1) + 60'h0AB_0000_0000_0000;
      b2b_k[i] = 60'h55 << (i * 9);
    end
    cyc = 0; n_acc = 0; n_out = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    data_to_be_decrypt = ref_encrypt(b2b_p[0], b2b_k[0], TB_ROUNDS);
    key = b2b_k[0];
    while (n_out < 3 && cyc < 100) begin
      acc_now = in_ready & in_valid;
      if (out_valid) begin
        checkOutput("b2b_plain", 64'(output_decrypted), 64'(b2b_p[n_out]));
        n_out++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          data_to_be_decrypt = ref_encrypt(b2b_p[n_acc], b2b_k[n_acc], TB_ROUNDS);
          key = b2b_k[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_count", 64'({n_acc, n_out}), {32'd3, 32'd3});
    if (n_acc == 3) begin
      checkOutput("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(TB_ROUNDS + 3));
      checkOutput("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(TB_ROUNDS + 3));
    end
    repeat (3) tick();

    // Single-round instance: hand-computed vectors, good and flipped tag.
    for (int j = 0; j < 2; j++) begin
      in_valid1 = 1'b1;
      data_to_be_decrypt = (j == 0) ? 76'h8001_0000_0000_0000_080 : 76'h0001_0000_0000_0000_080;
      key = 60'h0;
      out_ready = 1'b1;
      tick();
      in_valid1 = 1'b0;
      data_to_be_decrypt = '1;
      key = '1;
      lat = 0;
      while (!out_valid1 && lat < 20) begin
        tick();
        lat++;
      end
      checkOutput("r1_latency", 64'(lat), 64'd2);
      checkOutput("r1_plain", 64'(output_decrypted1), 64'h1);
      checkOutput("r1_tag_ok", 64'(tag_ok1), (j == 0) ? 64'd1 : 64'd0);
      tick();
      checkOutput("r1_idle_after", 64'({in_ready1, busy1}), 64'b10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
